// File: rtl/overheat_annunciator.sv
// ============================================================================
// Module  : overheat_annunciator
// Brief   : Debounced engine overheat annunciator with lamps, horn, blinking
//           master warning and timed one-shot extinguisher discharge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module overheat_annunciator #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int BLINK_HALF   = 8,
  parameter int ACK_TIMEOUT  = 32,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eng1o,
  input  logic       eng2o,
  input  logic       emergencySignal,
  input  logic       ack,
  output logic       lamp1,
  output logic       lamp2,
  output logic       master_warn,
  output logic       horn,
  output logic       ext1_fire,
  output logic       ext2_fire,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ALERT     = 2'd1,
    S_DISCHARGE = 2'd2,
    S_ACKED     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_deb_last   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] c_tmo_last   = CNT_W'(ACK_TIMEOUT - 1);

  // Bit order: 0 = engine 1, 1 = engine 2, 2 = dual-engine emergency
  logic [2:0] w_raw;
  logic [2:0] w_deb;

  assign w_raw = {emergencySignal, eng2o, eng1o};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic [CNT_W-1:0] r_cnt;
      logic             r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_q   <= 1'b0;
        end else if (w_raw[gi] == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_last) begin
          r_q   <= w_raw[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_deb[gi] = r_q;
    end
  endgenerate

  logic w_d1;
  logic w_d2;
  logic w_de;
  logic w_any;
  logic w_rearm;
  logic w_to_idle;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_bcnt;
  logic             r_phase;
  logic             r_lamp1;
  logic             r_lamp2;
  logic             r_fired1;
  logic             r_fired2;

  assign w_d1  = w_deb[0];
  assign w_d2  = w_deb[1];
  assign w_de  = w_deb[2];
  assign w_any = w_d1 | w_d2 | w_de;

  // A debounced alarm whose lamp is not yet latched is a new event
  assign w_rearm   = ((w_d1 | w_de) & ~r_lamp1) | ((w_d2 | w_de) & ~r_lamp2);
  assign w_to_idle = (r_state == S_ACKED) && !w_any;

  always_comb begin
    w_next      = r_state;
    horn        = 1'b0;
    master_warn = 1'b0;
    ext1_fire   = 1'b0;
    ext2_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_ALERT;
      end
      S_ALERT: begin
        horn        = 1'b1;
        master_warn = r_phase;
        if (ack) begin
          w_next = S_ACKED;
        end else if (r_tmo == c_tmo_last) begin
          w_next = S_DISCHARGE;
        end
      end
      S_DISCHARGE: begin
        horn        = 1'b1;
        master_warn = 1'b1;
        ext1_fire   = r_lamp1 & ~r_fired1;
        ext2_fire   = r_lamp2 & ~r_fired2;
        w_next      = S_ACKED;
      end
      S_ACKED: begin
        master_warn = 1'b1;
        if (!w_any) begin
          w_next = S_IDLE;
        end else if (w_rearm) begin
          w_next = S_ALERT;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Timeout and blink phase run only while in ALERT, so every entry restarts them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_state != S_ALERT) begin
      r_tmo   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else begin
      r_tmo <= r_tmo + 1'b1;
      if (r_bcnt == c_blink_last) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lamp1  <= 1'b0;
      r_lamp2  <= 1'b0;
      r_fired1 <= 1'b0;
      r_fired2 <= 1'b0;
    end else if (w_to_idle) begin
      r_lamp1  <= 1'b0;
      r_lamp2  <= 1'b0;
      r_fired1 <= 1'b0;
      r_fired2 <= 1'b0;
    end else begin
      r_lamp1  <= r_lamp1 | w_d1 | w_de;
      r_lamp2  <= r_lamp2 | w_d2 | w_de;
      r_fired1 <= r_fired1 | ext1_fire;
      r_fired2 <= r_fired2 | ext2_fire;
    end
  end

  assign lamp1 = r_lamp1;
  assign lamp2 = r_lamp2;
  assign state = r_state;

endmodule

`default_nettype wire
